vector_loader: RTL and testbench

- Producer side of the dot-product datapath: accepts a serial stream of (a_i, b_i) element pairs and packs them into DIM-wide A and B vectors.
- The packed vectors use exactly the layout the dot-product engine consumes: element i sits at bits [i*WIDTH +: WIDTH].
- Ping-pong double buffer, so one vector is filled while the previous one waits for, or is taken by, the downstream engine. Sustains one element per cycle.
- Ready/valid handshakes on both sides; early termination zero-pads the vector.

---
 rtl/vector_loader_if.sv | 30 +++
 rtl/vector_loader.sv | 99 +++++++++
 tb/tb_vector_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_loader_if.sv
// Stream-in / vector-out bundle for vector_loader: element pairs enter on the
// In* side, packed DIM-wide A/B vectors leave on the Out side.
interface vector_loader_if #(
  parameter int DIM          = 8,
  parameter int A_DATA_WIDTH = 32,
  parameter int B_DATA_WIDTH = 32
);
  localparam int LEN_WIDTH = $clog2(DIM + 1);

  logic                          InValid;
  logic                          InReady;
  logic [A_DATA_WIDTH-1:0]       InA;
  logic [B_DATA_WIDTH-1:0]       InB;
  logic                          InLast;
  logic                          OutValid;
  logic                          OutReady;
  logic [DIM*A_DATA_WIDTH-1:0]   A;
  logic [DIM*B_DATA_WIDTH-1:0]   B;
  logic [LEN_WIDTH-1:0]          OutLen;

  modport master (
    output InValid, InA, InB, InLast, OutReady,
    input  InReady, OutValid, A, B, OutLen
  );

  modport slave (
    input  InValid, InA, InB, InLast, OutReady,
    output InReady, OutValid, A, B, OutLen
  );
endinterface

// File: rtl/vector_loader.sv
// Ping-pong packer: collects (a_i, b_i) pairs into one of two buffers while the
// other is presented downstream; freed buffers are zeroed so short vectors pad.
module vector_loader #(
  parameter int DIM          = 8,
  parameter int A_DATA_WIDTH = 32,
  parameter int B_DATA_WIDTH = 32
) (
  input logic           Clock,
  input logic           Reset_n,
  vector_loader_if.slave bus
);
  localparam int LEN_WIDTH = $clog2(DIM + 1);
  localparam int IDX_WIDTH = $clog2(DIM);
  localparam int AV_WIDTH  = DIM * A_DATA_WIDTH;
  localparam int BV_WIDTH  = DIM * B_DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIM - 1);

  logic [AV_WIDTH-1:0]  buf_a_q [2];
  logic [AV_WIDTH-1:0]  buf_a_d [2];
  logic [BV_WIDTH-1:0]  buf_b_q [2];
  logic [BV_WIDTH-1:0]  buf_b_d [2];
  logic [LEN_WIDTH-1:0] len_q   [2];
  logic [LEN_WIDTH-1:0] len_d   [2];
  logic [1:0]           full_q, full_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;

  logic in_ready, out_valid, in_fire, out_fire;

  assign in_ready  = ~full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];
  assign in_fire   = bus.InValid & in_ready;
  assign out_fire  = out_valid & bus.OutReady;

  // The read pointer can rest on the buffer being filled, so outputs are masked
  // by the full flag rather than relying on the buffer contents being zero.
  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.A        = out_valid ? buf_a_q[rd_ptr_q] : '0;
  assign bus.B        = out_valid ? buf_b_q[rd_ptr_q] : '0;
  assign bus.OutLen   = out_valid ? len_q[rd_ptr_q]   : '0;

  always_comb begin
    buf_a_d  = buf_a_q;
    buf_b_d  = buf_b_q;
    len_d    = len_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;

    if (out_fire) begin
      buf_a_d[rd_ptr_q] = '0;
      buf_b_d[rd_ptr_q] = '0;
      len_d[rd_ptr_q]   = '0;
      full_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = ~rd_ptr_q;
    end

    // out_fire needs full[rd] and in_fire needs !full[wr], so they never touch
    // the same buffer in one cycle.
    if (in_fire) begin
      buf_a_d[wr_ptr_q][idx_q*A_DATA_WIDTH +: A_DATA_WIDTH] = bus.InA;
      buf_b_d[wr_ptr_q][idx_q*B_DATA_WIDTH +: B_DATA_WIDTH] = bus.InB;
      if (bus.InLast || idx_q == LAST_IDX) begin
        full_d[wr_ptr_q] = 1'b1;
        len_d[wr_ptr_q]  = LEN_WIDTH'(idx_q) + LEN_WIDTH'(1);
        wr_ptr_d         = ~wr_ptr_q;
        idx_d            = '0;
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      buf_a_q[0] <= '0;
      buf_a_q[1] <= '0;
      buf_b_q[0] <= '0;
      buf_b_q[1] <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      idx_q      <= '0;
    end else begin
      buf_a_q  <= buf_a_d;
      buf_b_q  <= buf_b_d;
      len_q    <= len_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
    end
  end
endmodule

// File: tb/tb_vector_loader.sv
// Bench for vector_loader: a DIM=4/8-bit instance for vectors, backpressure and
// random traffic, plus a DIM=10/16-bit instance for streaming throughput.
module tb_vector_loader;
  logic Clock = 1'b0;
  logic rst4_n = 1'b0;
  logic rst10_n = 1'b0;

  always #5 Clock = ~Clock;

  vector_loader_if #(.DIM(4), .A_DATA_WIDTH(8), .B_DATA_WIDTH(8)) bus4 ();
  vector_loader_if #(.DIM(10), .A_DATA_WIDTH(16), .B_DATA_WIDTH(16)) bus10 ();

  vector_loader #(.DIM(4), .A_DATA_WIDTH(8), .B_DATA_WIDTH(8)) u_dut4 (
    .Clock(Clock), .Reset_n(rst4_n), .bus(bus4)
  );
  vector_loader #(.DIM(10), .A_DATA_WIDTH(16), .B_DATA_WIDTH(16)) u_dut10 (
    .Clock(Clock), .Reset_n(rst10_n), .bus(bus10)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          n;
    logic        last;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [2:0]  exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          len;
  } mvec_t;

  vec_t tbl [5];

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic last, input logic rdy);
    bus4.InValid  = v;
    bus4.InA      = a;
    bus4.InB      = b;
    bus4.InLast   = last;
    bus4.OutReady = rdy;
  endtask

  task automatic reset4();
    apply_stimulus(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
  endtask

  initial begin
    logic        v, r, l;
    logic [7:0]  ra, rb;
    mvec_t       mq [$];
    logic [7:0]  pa [$];
    logic [7:0]  pb [$];
    mvec_t       e;
    logic        in_fire, out_fire;
    int          dot, prev, pulses;

    tbl[0] = '{n:4, last:1'b0, a_in:32'h04030201, b_in:32'h08070605,
               exp_a:32'h04030201, exp_b:32'h08070605, exp_len:3'd4};
    tbl[1] = '{n:2, last:1'b1, a_in:32'hAAAA0909, b_in:32'h55550303,
               exp_a:32'h00000909, exp_b:32'h00000303, exp_len:3'd2};
    tbl[2] = '{n:1, last:1'b1, a_in:32'hFFFFFF7F, b_in:32'hFFFFFF80,
               exp_a:32'h0000007F, exp_b:32'h00000080, exp_len:3'd1};
    tbl[3] = '{n:4, last:1'b1, a_in:32'hDEADBEEF, b_in:32'h01020304,
               exp_a:32'hDEADBEEF, exp_b:32'h01020304, exp_len:3'd4};
    tbl[4] = '{n:3, last:1'b1, a_in:32'h11223344, b_in:32'hA0B0C0D0,
               exp_a:32'h00223344, exp_b:32'h00B0C0D0, exp_len:3'd3};

    apply_stimulus(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    bus10.InValid = 1'b0; bus10.InA = '0; bus10.InB = '0;
    bus10.InLast = 1'b0; bus10.OutReady = 1'b0;
    tick();
    tick();
    rst4_n = 1'b1;
    rst10_n = 1'b1;

    check_output("rst_in_ready", bus4.InReady, 1);
    check_output("rst_out_valid", bus4.OutValid, 0);
    check_output("rst_a", bus4.A, 0);
    check_output("rst_b", bus4.B, 0);
    check_output("rst_len", bus4.OutLen, 0);

    // Reset with one complete and one partial vector held inside.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'(8'h11 + i), 8'(8'h21 + i), 1'b0, 1'b0);
      tick();
    end
    bus4.InValid = 1'b0;
    check_output("prerst_out_valid", bus4.OutValid, 1);
    rst4_n = 1'b0;
    #1;
    check_output("midrst_out_valid", bus4.OutValid, 0);
    check_output("midrst_a", bus4.A, 0);
    check_output("midrst_b", bus4.B, 0);
    check_output("midrst_in_ready", bus4.InReady, 1);
    check_output("midrst_len", bus4.OutLen, 0);
    tick();
    rst4_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'h0D - i), 8'(i + 1), 1'b0, 1'b1);
      tick();
    end
    bus4.InValid = 1'b0;
    check_output("postrst_out_valid", bus4.OutValid, 1);
    check_output("postrst_a", bus4.A, 32'h0A0B0C0D);
    check_output("postrst_b", bus4.B, 32'h04030201);
    check_output("postrst_len", bus4.OutLen, 4);
    tick();

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        check_output($sformatf("vec%0d_in_ready", t), bus4.InReady, 1);
        apply_stimulus(1'b1, tbl[t].a_in[i*8 +: 8], tbl[t].b_in[i*8 +: 8],
                       tbl[t].last && (i == tbl[t].n - 1), 1'b1);
        tick();
      end
      bus4.InValid = 1'b0;
      bus4.InLast  = 1'b0;
      check_output($sformatf("vec%0d_out_valid", t), bus4.OutValid, 1);
      check_output($sformatf("vec%0d_a", t), bus4.A, tbl[t].exp_a);
      check_output($sformatf("vec%0d_b", t), bus4.B, tbl[t].exp_b);
      check_output($sformatf("vec%0d_len", t), bus4.OutLen, tbl[t].exp_len);
      tick();
      check_output($sformatf("vec%0d_drained", t), bus4.OutValid, 0);
      check_output($sformatf("vec%0d_zero_a", t), bus4.A, 0);
    end

    // Backpressure: twelve elements offered while the consumer stalls.
    reset4();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 8'(i + 1), 8'(8'h80 + i), 1'b0, 1'b0);
      tick();
    end
    apply_stimulus(1'b1, 8'd9, 8'h88, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_output("bp_in_ready", bus4.InReady, 0);
      check_output("bp_out_valid", bus4.OutValid, 1);
      check_output("bp_stable_a", bus4.A, 32'h04030201);
      check_output("bp_stable_b", bus4.B, 32'h83828180);
      tick();
    end
    bus4.OutReady = 1'b1;
    tick();
    check_output("bp_vec2_valid", bus4.OutValid, 1);
    check_output("bp_vec2_a", bus4.A, 32'h08070605);
    check_output("bp_vec2_b", bus4.B, 32'h87868584);
    check_output("bp_freed_ready", bus4.InReady, 1);
    tick();
    check_output("bp_partial_hidden", bus4.OutValid, 0);
    for (int i = 9; i < 12; i++) begin
      apply_stimulus(1'b1, 8'(i + 1), 8'(8'h80 + i), 1'b0, 1'b1);
      tick();
    end
    bus4.InValid = 1'b0;
    check_output("bp_vec3_valid", bus4.OutValid, 1);
    check_output("bp_vec3_a", bus4.A, 32'h0C0B0A09);
    check_output("bp_vec3_b", bus4.B, 32'h8B8A8988);
    check_output("bp_vec3_len", bus4.OutLen, 4);
    tick();
    check_output("bp_empty", bus4.OutValid, 0);

    // Completion of one buffer on the same edge the other is taken.
    reset4();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) apply_stimulus(1'b1, 8'(8'h21 + i), 8'(8'h31 + i), 1'b0, 1'b0);
      else       apply_stimulus(1'b1, 8'(8'h41 + i - 4), 8'(8'h51 + i - 4), 1'b0, 1'b0);
      tick();
    end
    check_output("sim_pre_ready", bus4.InReady, 1);
    check_output("sim_x_a", bus4.A, 32'h24232221);
    check_output("sim_x_b", bus4.B, 32'h34333231);
    apply_stimulus(1'b1, 8'h44, 8'h54, 1'b0, 1'b1);
    tick();
    check_output("sim_y_valid", bus4.OutValid, 1);
    check_output("sim_y_a", bus4.A, 32'h44434241);
    check_output("sim_y_b", bus4.B, 32'h54535251);
    check_output("sim_ready", bus4.InReady, 1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'h61 + i), 8'(8'h71 + i), 1'b0, 1'b1);
      tick();
      if (i == 0) check_output("sim_y_taken", bus4.OutValid, 0);
      check_output("sim_z_ready", bus4.InReady, 1);
    end
    bus4.InValid = 1'b0;
    check_output("sim_z_a", bus4.A, 32'h64636261);
    check_output("sim_z_b", bus4.B, 32'h74737271);
    tick();
    check_output("sim_z_taken", bus4.OutValid, 0);

    // Random traffic against a queue-of-vectors model with two buffer slots.
    reset4();
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 6);
      l  = ($urandom_range(0, 4) == 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      apply_stimulus(v, ra, rb, l, r);
      check_output("rand_in_ready", bus4.InReady, (mq.size() < 2) ? 1 : 0);
      check_output("rand_out_valid", bus4.OutValid, (mq.size() > 0) ? 1 : 0);
      check_output("rand_a", bus4.A, (mq.size() > 0) ? mq[0].a : 0);
      check_output("rand_b", bus4.B, (mq.size() > 0) ? mq[0].b : 0);
      check_output("rand_len", bus4.OutLen, (mq.size() > 0) ? mq[0].len : 0);
      in_fire  = v && (mq.size() < 2);
      out_fire = r && (mq.size() > 0);
      if (out_fire) void'(mq.pop_front());
      if (in_fire) begin
        pa.push_back(ra);
        pb.push_back(rb);
        if (pa.size() == 4 || l) begin
          e = '{a:32'h0, b:32'h0, len:pa.size()};
          for (int k = 0; k < pa.size(); k++) begin
            e.a[k*8 +: 8] = pa[k];
            e.b[k*8 +: 8] = pb[k];
          end
          mq.push_back(e);
          pa.delete();
          pb.delete();
        end
      end
      tick();
    end
    bus4.InValid = 1'b0;

    // Streaming throughput on the wide instance: all elements 8, 8*8*10 = 640.
    bus10.InValid  = 1'b1;
    bus10.InA      = 16'd8;
    bus10.InB      = 16'd8;
    bus10.OutReady = 1'b1;
    prev   = 0;
    pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus10.InReady !== 1'b1) check_output("tp_in_ready", bus10.InReady, 1);
      if (bus10.OutValid === 1'b1) begin
        dot = 0;
        for (int k = 0; k < 10; k++)
          dot += int'(bus10.A[k*16 +: 16]) * int'(bus10.B[k*16 +: 16]);
        check_output("tp_dot", dot, 640);
        check_output("tp_len", bus10.OutLen, 10);
        check_output("tp_period", c - prev, 10);
        prev = c;
        pulses++;
      end
    end
    bus10.InValid = 1'b0;
    check_output("tp_pulses", pulses, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
